// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants and the response record for dmem_arbiter.
package dmem_arb_pkg;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned DMEM_BYTES        = 4096;
  localparam int unsigned DEFAULT_ADDR_BITS = $clog2(DMEM_BYTES);

  typedef struct packed {
    logic vld;
    logic id;
    logic is_load;
    logic err;
  } rsp_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's valid/ready request channel plus its
// response pulse. master = requester side, slave = arbiter side.
interface dmem_arbiter_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_arbiter_arb2_pick.sv
// arb2_pick: combinational two-way grant. req[0] is port C, req[1] is port D.
// On conflict prio selects the winner (0 = C, 1 = D); gnt is one-hot or zero.
module arb2_pick (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // Pass a lone request straight through, resolve a conflict by prio.
  always_comb begin
    gnt = '0;
    if (req[0] && req[1]) begin
      gnt = prio ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data_mem between the core (port C)
// and a DMA/loader (port D). One accept per cycle, memory strobes in the
// accept cycle, one in-order response exactly one cycle later. Out-of-range
// addresses are answered with err and never reach memory.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with C first.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  c,
  dmem_arbiter_if.slave  d,
  output logic           mem_re,
  output logic [31:0]    mem_raddr,
  output logic           mem_we,
  output logic [31:0]    mem_waddr,
  output logic [31:0]    mem_wdata,
  output logic [3:0]     mem_wstrb,
  input  logic [31:0]    mem_rdata
);

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        prio;
  logic        accept;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        in_range;
  rsp_t        rsp;
  logic        resp_live;
  logic [31:0] resp_data;

  // Reset masks the requests so no ready or strobe can appear while rst is high.
  assign req = {d.req_valid, c.req_valid} & {2{~rst}};

`ifdef DMEM_ARB_RR_EN
  logic last_grant;

  // Remember the most recent winner; reset as if D went last so C is favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_D;
    end else if (accept) begin
      last_grant <= gnt[1];
    end
  end

  assign prio = ~last_grant;
`else
  assign prio = PORT_C;
`endif

  arb2_pick u_pick (
    .req  (req),
    .prio (prio),
    .gnt  (gnt)
  );

  assign accept      = |gnt;
  assign sel         = gnt[1];
  assign c.req_ready = gnt[0];
  assign d.req_ready = gnt[1];

  // Steer the granted port's request fields onto a single request path.
  always_comb begin
    sel_we    = c.req_we;
    sel_addr  = c.req_addr;
    sel_wdata = c.req_wdata;
    sel_wstrb = c.req_wstrb;
    if (sel == PORT_D) begin
      sel_we    = d.req_we;
      sel_addr  = d.req_addr;
      sel_wdata = d.req_wdata;
      sel_wstrb = d.req_wstrb;
    end
  end

  assign in_range = (sel_addr >> ADDR_BITS) == 32'd0;

  // Drive exactly one memory port for an accepted in-range request, none otherwise.
  always_comb begin
    mem_re    = 1'b0;
    mem_raddr = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (accept && in_range) begin
      if (sel_we) begin
        mem_we    = 1'b1;
        mem_waddr = sel_addr;
        mem_wdata = sel_wdata;
        mem_wstrb = sel_wstrb;
      end else begin
        mem_re    = 1'b1;
        mem_raddr = sel_addr;
      end
    end
  end

  // Capture who gets answered next cycle; idle cycles clear it so responses pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp <= '0;
    end else if (accept) begin
      rsp.vld     <= 1'b1;
      rsp.id      <= sel;
      rsp.is_load <= ~sel_we;
      rsp.err     <= ~in_range;
    end else begin
      rsp <= '0;
    end
  end

  // A response falling in a reset cycle is dropped rather than delayed.
  assign resp_live = rsp.vld & ~rst;
  assign resp_data = (rsp.is_load && !rsp.err) ? mem_rdata : '0;

  assign c.resp_valid = resp_live & (rsp.id == PORT_C);
  assign c.resp_rdata = c.resp_valid ? resp_data : '0;
  assign c.resp_err   = c.resp_valid & rsp.err;

  assign d.resp_valid = resp_live & (rsp.id == PORT_D);
  assign d.resp_rdata = d.resp_valid ? resp_data : '0;
  assign d.resp_err   = d.resp_valid & rsp.err;

endmodule
